// File: rtl/clock_time_ctrl.sv
// Alarm clock mode/time-keeping controller.
// Owns HH:MM:SS time, HH:MM alarm, the set-mode FSM and the ring latch.
module clock_time_ctrl #(
  parameter int RING_SEC = 60,
  parameter int HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       alarm_en,
  output logic       run_en,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [4:0] al_hours,
  output logic [5:0] al_minutes,
  output logic [2:0] mode,
  output logic       alarm_ring
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SET_HR   = 3'd1,
    SET_MIN  = 3'd2,
    SET_AHR  = 3'd3,
    SET_AMIN = 3'd4
  } mode_e;

  localparam logic [4:0] HMAX = 5'(HOUR_MAX);
  localparam logic [5:0] RLAST = 6'(RING_SEC - 1);

  mode_e      mode_q;
  logic [4:0] hours_q, al_hours_q;
  logic [5:0] minutes_q, seconds_q, al_minutes_q;
  logic       ring_q;
  logic [5:0] rcnt_q;

  logic       tk;
  logic       consume;
  logic       adv;
  logic       inc;
  logic       ring_hit;
  logic [5:0] sec_d;
  logic [5:0] min_d;
  logic [4:0] hr_d;

  // The prescaler only runs while the time fields are not being edited.
  assign run_en = !(mode_q == SET_HR || mode_q == SET_MIN);

  // Next time on a tick, button qualification and alarm match.
  always_comb begin
    tk      = tick & run_en;
    consume = ring_q & (btn_mode | btn_inc);
    adv     = btn_mode & ~consume;
    inc     = btn_inc & ~btn_mode & ~ring_q;
    sec_d   = seconds_q;
    min_d   = minutes_q;
    hr_d    = hours_q;
    if (seconds_q == 6'd59) begin
      sec_d = 6'd0;
      if (minutes_q == 6'd59) begin
        min_d = 6'd0;
        hr_d  = (hours_q == HMAX) ? 5'd0 : hours_q + 5'd1;
      end else begin
        min_d = minutes_q + 6'd1;
      end
    end else begin
      sec_d = seconds_q + 6'd1;
    end
    ring_hit = alarm_en & tk & (sec_d == 6'd0) &
               (min_d == al_minutes_q) & (hr_d == al_hours_q);
  end

  // Mode FSM: one step per accepted btn_mode, illegal codes fall to RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= RUN;
    end else begin
      case (mode_q)
        RUN:      if (adv) mode_q <= SET_HR;
        SET_HR:   if (adv) mode_q <= SET_MIN;
        SET_MIN:  if (adv) mode_q <= SET_AHR;
        SET_AHR:  if (adv) mode_q <= SET_AMIN;
        SET_AMIN: if (adv) mode_q <= RUN;
        default:  mode_q <= RUN;
      endcase
    end
  end

  // Time and alarm registers: tick carries, btn_inc edits one field only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hours_q      <= 5'd0;
      minutes_q    <= 6'd0;
      seconds_q    <= 6'd0;
      al_hours_q   <= 5'd0;
      al_minutes_q <= 6'd0;
    end else begin
      if (tk) begin
        seconds_q <= sec_d;
        minutes_q <= min_d;
        hours_q   <= hr_d;
      end
      if (adv && mode_q == RUN) begin
        seconds_q <= 6'd0;
      end
      if (inc) begin
        case (mode_q)
          SET_HR:
            hours_q <= (hours_q == HMAX) ? 5'd0 : hours_q + 5'd1;
          SET_MIN:
            minutes_q <= (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
          SET_AHR:
            al_hours_q <= (al_hours_q == HMAX) ? 5'd0 : al_hours_q + 5'd1;
          SET_AMIN:
            al_minutes_q <= (al_minutes_q == 6'd59) ? 6'd0
                                                     : al_minutes_q + 6'd1;
          default: ;
        endcase
      end
    end
  end

  // Ring latch: set on an alarm match, cleared by button, disarm or timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ring_q <= 1'b0;
      rcnt_q <= 6'd0;
    end else if (!ring_q) begin
      if (ring_hit) begin
        ring_q <= 1'b1;
        rcnt_q <= 6'd0;
      end
    end else if (btn_mode || btn_inc || !alarm_en) begin
      ring_q <= 1'b0;
    end else if (tick) begin
      if (rcnt_q == RLAST) ring_q <= 1'b0;
      else                 rcnt_q <= rcnt_q + 6'd1;
    end
  end

  assign hours      = hours_q;
  assign minutes    = minutes_q;
  assign seconds    = seconds_q;
  assign al_hours   = al_hours_q;
  assign al_minutes = al_minutes_q;
  assign mode       = mode_q;
  assign alarm_ring = ring_q;

endmodule
